// File: rtl/tagged_regfile_pkg.sv
// Shared types and default widths for the tagged register file, the
// reservation stations and the CDB arbiter.
package tagged_regfile_pkg;

    localparam int unsigned DEF_DATA_W   = 64;
    localparam int unsigned DEF_TAG_W    = 4;
    localparam int unsigned DEF_NUM_REGS = 32;
    localparam int unsigned DEF_AW       = $clog2(DEF_NUM_REGS);

    typedef logic [DEF_TAG_W-1:0] tag_t;
    typedef logic [DEF_AW-1:0]    reg_idx_t;

endpackage

// File: rtl/tagged_regfile_if.sv
// Bus bundle of the tagged register file: read ports, rename (alloc),
// common data bus, flush and the busy counter.
//   master : issue/writeback side, drives requests and samples results
//   slave  : the register file itself
interface tagged_regfile_if
    import tagged_regfile_pkg::*;
#(
    parameter int unsigned DATA_W   = DEF_DATA_W,
    parameter int unsigned NUM_REGS = DEF_NUM_REGS,
    parameter int unsigned TAG_W    = DEF_TAG_W,
    parameter int unsigned NUM_RD   = 2
);
    localparam int unsigned AW = $clog2(NUM_REGS);

    logic [NUM_RD-1:0][AW-1:0]     rd_addr;
    logic [NUM_RD-1:0][DATA_W-1:0] rd_data;
    logic [NUM_RD-1:0]             rd_busy;
    logic [NUM_RD-1:0][TAG_W-1:0]  rd_tag;
    logic                          alloc_valid;
    logic [AW-1:0]                 alloc_reg;
    logic [TAG_W-1:0]              alloc_tag;
    logic                          cdb_valid;
    logic [TAG_W-1:0]              cdb_tag;
    logic [DATA_W-1:0]             cdb_data;
    logic                          flush;
    logic [AW:0]                   busy_count;

    modport master (
        output rd_addr, alloc_valid, alloc_reg, alloc_tag,
               cdb_valid, cdb_tag, cdb_data, flush,
        input  rd_data, rd_busy, rd_tag, busy_count
    );

    modport slave (
        input  rd_addr, alloc_valid, alloc_reg, alloc_tag,
               cdb_valid, cdb_tag, cdb_data, flush,
        output rd_data, rd_busy, rd_tag, busy_count
    );

endinterface

// File: rtl/regfile_entry.sv
// One architectural register: value, busy flag and producer tag.
// Exposes its post-edge (next) state combinationally so the top level can
// forward same-cycle updates into the read ports and the busy counter.
//   clk_in, reset      : clock, async active-low reset
//   alloc_*            : rename request (matched against IDX)
//   cdb_*              : result broadcast (matched against stored tag)
//   flush              : clear busy, keep value
//   *_nxt_c            : next-state view of this register
module regfile_entry
    import tagged_regfile_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned TAG_W  = DEF_TAG_W,
    parameter int unsigned AW     = DEF_AW,
    parameter int unsigned IDX    = 0
) (
    input  logic              clk_in,
    input  logic              reset,
    input  logic              alloc_valid,
    input  logic [AW-1:0]     alloc_reg,
    input  logic [TAG_W-1:0]  alloc_tag,
    input  logic              cdb_valid,
    input  logic [TAG_W-1:0]  cdb_tag,
    input  logic [DATA_W-1:0] cdb_data,
    input  logic              flush,
    output logic [DATA_W-1:0] value_nxt_c,
    output logic              busy_nxt_c,
    output logic [TAG_W-1:0]  tag_nxt_c
);

    logic [DATA_W-1:0] value;
    logic              busy;
    logic [TAG_W-1:0]  tag;
    logic              cdb_hit;
    logic              alloc_hit;

    // Next-state: CDB writes value even during flush; flush beats alloc;
    // a same-cycle alloc keeps the register pending under the newer tag.
    always_comb begin
        cdb_hit     = busy && cdb_valid && (cdb_tag == tag);
        alloc_hit   = alloc_valid && !flush && (alloc_reg == AW'(IDX));
        value_nxt_c = value;
        busy_nxt_c  = busy;
        tag_nxt_c   = tag;
        if (cdb_hit) begin
            value_nxt_c = cdb_data;
            busy_nxt_c  = 1'b0;
        end
        if (alloc_hit) begin
            busy_nxt_c = 1'b1;
            tag_nxt_c  = alloc_tag;
        end
        if (flush) begin
            busy_nxt_c = 1'b0;
        end
    end

    // State register
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            value <= '0;
            busy  <= 1'b0;
            tag   <= '0;
        end else begin
            value <= value_nxt_c;
            busy  <= busy_nxt_c;
            tag   <= tag_nxt_c;
        end
    end

endmodule

// File: rtl/tagged_regfile.sv
// Tagged architectural register file with register renaming support.
// Reads are registered and show the post-update view of the addressed
// register; busy_count tracks pending registers after each edge.
//   clk_in : clock
//   reset  : async active-low reset
//   bus    : tagged_regfile_if slave (read ports, alloc, CDB, flush, count)
module tagged_regfile
    import tagged_regfile_pkg::*;
#(
    parameter int unsigned DATA_W   = DEF_DATA_W,
    parameter int unsigned NUM_REGS = DEF_NUM_REGS,
    parameter int unsigned TAG_W    = DEF_TAG_W,
    parameter int unsigned NUM_RD   = 2,
    parameter int unsigned ZERO_REG = 31
) (
    input  logic            clk_in,
    input  logic            reset,
    tagged_regfile_if.slave bus
);

    localparam int unsigned AW = $clog2(NUM_REGS);
    localparam int unsigned CW = AW + 1;

    logic [DATA_W-1:0]   value_nxt [NUM_REGS];
    logic [NUM_REGS-1:0] busy_nxt;
    logic [TAG_W-1:0]    tag_nxt   [NUM_REGS];
    logic [CW-1:0]       count_c;

    // Register array; the zero register is a constant, never renamed
    for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
        if (i == ZERO_REG) begin : g_zero
            assign value_nxt[i] = '0;
            assign busy_nxt[i]  = 1'b0;
            assign tag_nxt[i]   = '0;
        end else begin : g_entry
            regfile_entry #(
                .DATA_W (DATA_W),
                .TAG_W  (TAG_W),
                .AW     (AW),
                .IDX    (i)
            ) u_entry (
                .clk_in      (clk_in),
                .reset       (reset),
                .alloc_valid (bus.alloc_valid),
                .alloc_reg   (bus.alloc_reg),
                .alloc_tag   (bus.alloc_tag),
                .cdb_valid   (bus.cdb_valid),
                .cdb_tag     (bus.cdb_tag),
                .cdb_data    (bus.cdb_data),
                .flush       (bus.flush),
                .value_nxt_c (value_nxt[i]),
                .busy_nxt_c  (busy_nxt[i]),
                .tag_nxt_c   (tag_nxt[i])
            );
        end
    end

    // Population count of the post-update busy flags
    always_comb begin
        count_c = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            count_c = count_c + CW'(busy_nxt[i]);
        end
    end

    // Registered read ports and counter, fed from next-state for forwarding
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            bus.rd_data    <= '0;
            bus.rd_busy    <= '0;
            bus.rd_tag     <= '0;
            bus.busy_count <= '0;
        end else begin
            for (int p = 0; p < NUM_RD; p++) begin
                bus.rd_data[p] <= value_nxt[bus.rd_addr[p]];
                bus.rd_busy[p] <= busy_nxt[bus.rd_addr[p]];
                bus.rd_tag[p]  <= tag_nxt[bus.rd_addr[p]];
            end
            bus.busy_count <= count_c;
        end
    end

endmodule
